// File: rtl/snake_dir_queue.sv
// Keyboard direction control for the snake game: decodes PS/2 make codes into
// directions, buffers pending turns in a small FIFO, filters reversals and
// duplicates, handles pause, and gates the game tick into step_out.
module snake_dir_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [1:0]  INIT_DIR  = 2'd1,
    parameter logic [7:0]  KEY_UP    = 8'h1D,
    parameter logic [7:0]  KEY_RIGHT = 8'h23,
    parameter logic [7:0]  KEY_DOWN  = 8'h1B,
    parameter logic [7:0]  KEY_LEFT  = 8'h1C,
    parameter logic [7:0]  KEY_PAUSE = 8'h29
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   key,
    input  logic                         key_pressed,
    input  logic                         step,
    input  logic                         start,
    output logic [1:0]                   snake_dir,
    output logic                         step_out,
    output logic                         paused,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic                         drop
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]    fifo_q [DEPTH];
    logic [1:0]    fifo_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    snake_dir_q, snake_dir_d;
    logic          step_out_q, step_out_d;
    logic          paused_q, paused_d;
    logic          drop_q, drop_d;
    logic          brk_q, brk_d;

    logic [1:0]    key_dir;
    logic          key_is_dir;
    logic [PW-1:0] tail_idx;
    logic [1:0]    last_dir;
    logic          do_step;
    logic          do_pop;
    logic          push;

    // Pointers wrap at DEPTH, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Map the incoming byte to a direction, if it is one of the four keys.
    always_comb begin
        key_is_dir = 1'b1;
        key_dir    = 2'd0;
        if (key == KEY_UP) begin
            key_dir = 2'd0;
        end else if (key == KEY_RIGHT) begin
            key_dir = 2'd1;
        end else if (key == KEY_DOWN) begin
            key_dir = 2'd2;
        end else if (key == KEY_LEFT) begin
            key_dir = 2'd3;
        end else begin
            key_is_dir = 1'b0;
        end
    end

    // New turns are judged against the newest queued turn, or the live
    // direction when nothing is queued (pre-pop view).
    always_comb begin
        tail_idx = (wr_ptr_q == '0) ? LAST_IDX : wr_ptr_q - 1'b1;
        last_dir = (count_q != '0) ? fifo_q[tail_idx] : snake_dir_q;
    end

    // Next-state: key decode, push/pop, tick gating; start overrides all.
    always_comb begin
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        snake_dir_d = snake_dir_q;
        paused_d    = paused_q;
        brk_d       = brk_q;
        step_out_d  = 1'b0;
        drop_d      = 1'b0;
        push        = 1'b0;

        do_step = step & ~paused_q;
        do_pop  = do_step && (count_q != '0);

        if (key_pressed) begin
            if (key == 8'hF0) begin
                brk_d = 1'b1;
            end else if (key == 8'hE0) begin
                // Extended-key prefix: carries nothing for us, break flag kept.
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else if (key == KEY_PAUSE) begin
                paused_d = ~paused_q;
            end else if (key_is_dir && !paused_q && (key_dir != last_dir) &&
                         (key_dir != (last_dir ^ 2'd2))) begin
                // A pop in the same cycle frees a slot for this push.
                if ((count_q != FULL_CNT) || do_pop) begin
                    push = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end

        step_out_d = do_step;

        if (do_pop) begin
            snake_dir_d = fifo_q[rd_ptr_q];
            rd_ptr_d    = ptr_inc(rd_ptr_q);
        end

        if (push) begin
            fifo_d[wr_ptr_q] = key_dir;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end

        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end

        if (start) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            snake_dir_d = INIT_DIR;
            paused_d    = 1'b0;
            brk_d       = 1'b0;
            step_out_d  = 1'b0;
            drop_d      = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 2'd0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            snake_dir_q <= INIT_DIR;
            step_out_q  <= 1'b0;
            paused_q    <= 1'b0;
            drop_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            snake_dir_q <= snake_dir_d;
            step_out_q  <= step_out_d;
            paused_q    <= paused_d;
            drop_q      <= drop_d;
            brk_q       <= brk_d;
        end
    end

    assign snake_dir   = snake_dir_q;
    assign step_out    = step_out_q;
    assign paused      = paused_q;
    assign queue_count = count_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Bench for snake_dir_queue: a DEPTH=4 instance checked against a cycle table
// and a list-based model, and a DEPTH=3 instance checked against the model.
module tb_snake_dir_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key = 8'h00;
    logic       key_pressed = 1'b0;
    logic       step = 1'b0;
    logic       start = 1'b0;

    logic [1:0] d4_dir, d3_dir;
    logic       d4_so, d3_so, d4_p, d3_p, d4_drop, d3_drop;
    logic [2:0] d4_cnt;
    logic [1:0] d3_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    snake_dir_queue #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .key(key), .key_pressed(key_pressed), .step(step),
        .start(start), .snake_dir(d4_dir), .step_out(d4_so), .paused(d4_p),
        .queue_count(d4_cnt), .drop(d4_drop)
    );

    snake_dir_queue #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .key(key), .key_pressed(key_pressed), .step(step),
        .start(start), .snake_dir(d3_dir), .step_out(d3_so), .paused(d3_p),
        .queue_count(d3_cnt), .drop(d3_drop)
    );

    // Reference model: pending turns kept as a plain ordered list (index 0 = oldest).
    int m_f[2][8];
    int m_cnt[2], m_dir[2], m_p[2], m_brk[2], m_so[2], m_drop[2];
    int m_depth[2] = '{4, 3};

    function automatic int key2dir(input logic [7:0] k);
        case (k)
            8'h1D:   return 0;
            8'h23:   return 1;
            8'h1B:   return 2;
            8'h1C:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic void model_reset(input int i);
        m_cnt[i] = 0; m_dir[i] = 1; m_p[i] = 0; m_brk[i] = 0; m_so[i] = 0; m_drop[i] = 0;
    endfunction

    function automatic void model_step(input int i, input bit kp, input logic [7:0] k,
                                       input bit stp, input bit st);
        int  d, last;
        bit  so, pop, push;
        if (st) begin
            model_reset(i);
            return;
        end
        so = stp && (m_p[i] == 0);
        pop = so && (m_cnt[i] > 0);
        push = 0;
        m_drop[i] = 0;
        d = key2dir(k);
        if (kp) begin
            if (k == 8'hF0) m_brk[i] = 1;
            else if (k == 8'hE0) m_brk[i] = m_brk[i];
            else if (m_brk[i] != 0) m_brk[i] = 0;
            else if (k == 8'h29) m_p[i] = 1 - m_p[i];
            else if (d >= 0 && m_p[i] == 0) begin
                last = (m_cnt[i] > 0) ? m_f[i][m_cnt[i] - 1] : m_dir[i];
                if (d != last && d != (last ^ 2)) begin
                    if (m_cnt[i] < m_depth[i] || pop) push = 1;
                    else m_drop[i] = 1;
                end
            end
        end
        if (pop) begin
            m_dir[i] = m_f[i][0];
            for (int j = 0; j < 7; j++) m_f[i][j] = m_f[i][j + 1];
            m_cnt[i]--;
        end
        if (push) begin
            m_f[i][m_cnt[i]] = d;
            m_cnt[i]++;
        end
        m_so[i] = so;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model4(input string tag);
        check({tag, " d4 dir"}, int'(d4_dir), m_dir[0]);
        check({tag, " d4 step_out"}, int'(d4_so), m_so[0]);
        check({tag, " d4 paused"}, int'(d4_p), m_p[0]);
        check({tag, " d4 count"}, int'(d4_cnt), m_cnt[0]);
        check({tag, " d4 drop"}, int'(d4_drop), m_drop[0]);
    endtask

    task automatic check_model3(input string tag);
        check({tag, " d3 dir"}, int'(d3_dir), m_dir[1]);
        check({tag, " d3 step_out"}, int'(d3_so), m_so[1]);
        check({tag, " d3 paused"}, int'(d3_p), m_p[1]);
        check({tag, " d3 count"}, int'(d3_cnt), m_cnt[1]);
        check({tag, " d3 drop"}, int'(d3_drop), m_drop[1]);
    endtask

    // One clock: drive at negedge, clock edge, sample at the following negedge.
    task automatic drive_cycle(input bit kp, input logic [7:0] k, input bit stp, input bit st);
        key_pressed = kp; key = k; step = stp; start = st;
        @(posedge clk);
        @(negedge clk);
        model_step(0, kp, k, stp, st);
        model_step(1, kp, k, stp, st);
        key_pressed = 1'b0; key = 8'h00; step = 1'b0; start = 1'b0;
    endtask

    typedef struct packed {
        logic       kp;
        logic [7:0] key;
        logic       stp;
        logic       st;
        logic [1:0] dir;
        logic       so;
        logic       p;
        logic [2:0] cnt;
        logic       drop;
    } vec_t;

    function automatic vec_t mkv(input bit kp, input logic [7:0] k, input bit stp, input bit st,
                                 input int dir, input int so, input int p, input int cnt,
                                 input int drp);
        vec_t v;
        v.kp = kp; v.key = k; v.stp = stp; v.st = st;
        v.dir = 2'(dir); v.so = 1'(so); v.p = 1'(p); v.cnt = 3'(cnt); v.drop = 1'(drp);
        return v;
    endfunction

    vec_t tbl[30];

    initial begin
        // Cycle-by-cycle expectations for the DEPTH=4 instance, starting from reset.
        //              kp  key    stp st  dir so p cnt drop
        tbl[0]  = mkv(0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 8'h00, 1, 0, 1, 1, 0, 0, 0);  // tick passes through
        tbl[2]  = mkv(0, 8'h00, 0, 0, 1, 0, 0, 0, 0);  // step_out lasts one cycle
        tbl[3]  = mkv(1, 8'h1D, 0, 0, 1, 0, 0, 1, 0);  // up queued
        tbl[4]  = mkv(1, 8'h1C, 0, 0, 1, 0, 0, 2, 0);  // left queued
        tbl[5]  = mkv(0, 8'h00, 1, 0, 0, 1, 0, 1, 0);
        tbl[6]  = mkv(0, 8'h00, 1, 0, 3, 1, 0, 0, 0);
        tbl[7]  = mkv(0, 8'h00, 0, 0, 3, 0, 0, 0, 0);
        tbl[8]  = mkv(1, 8'h23, 0, 0, 3, 0, 0, 0, 0);  // reverse of left
        tbl[9]  = mkv(1, 8'h1C, 0, 0, 3, 0, 0, 0, 0);  // duplicate
        tbl[10] = mkv(1, 8'h1D, 0, 0, 3, 0, 0, 1, 0);
        tbl[11] = mkv(1, 8'h23, 0, 0, 3, 0, 0, 2, 0);
        tbl[12] = mkv(1, 8'h1D, 0, 0, 3, 0, 0, 3, 0);
        tbl[13] = mkv(1, 8'h23, 0, 0, 3, 0, 0, 4, 0);
        tbl[14] = mkv(1, 8'h1B, 0, 0, 3, 0, 0, 4, 1);  // full: drop
        tbl[15] = mkv(0, 8'h00, 0, 0, 3, 0, 0, 4, 0);  // drop is one cycle
        tbl[16] = mkv(1, 8'h1B, 1, 0, 0, 1, 0, 4, 0);  // full + pop: accepted
        tbl[17] = mkv(0, 8'h00, 0, 0, 0, 0, 0, 4, 0);
        tbl[18] = mkv(1, 8'h29, 0, 0, 0, 0, 1, 4, 0);  // pause
        tbl[19] = mkv(0, 8'h00, 1, 0, 0, 0, 1, 4, 0);
        tbl[20] = mkv(0, 8'h00, 1, 0, 0, 0, 1, 4, 0);
        tbl[21] = mkv(1, 8'h1C, 1, 0, 0, 0, 1, 4, 0);  // key ignored while paused
        tbl[22] = mkv(1, 8'h29, 0, 0, 0, 0, 0, 4, 0);  // unpause
        tbl[23] = mkv(0, 8'h00, 1, 0, 1, 1, 0, 3, 0);
        tbl[24] = mkv(0, 8'h00, 0, 0, 1, 0, 0, 3, 0);
        tbl[25] = mkv(1, 8'hF0, 0, 0, 1, 0, 0, 3, 0);  // break prefix
        tbl[26] = mkv(1, 8'h1C, 0, 0, 1, 0, 0, 3, 0);  // released key, no push
        tbl[27] = mkv(1, 8'hE0, 0, 0, 1, 0, 0, 3, 0);
        tbl[28] = mkv(1, 8'h1C, 1, 1, 1, 0, 0, 0, 0);  // start wins over step and key
        tbl[29] = mkv(0, 8'h00, 0, 0, 1, 0, 0, 0, 0);

        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        check("reset dir", int'(d4_dir), 1);
        check("reset count", int'(d4_cnt), 0);
        check("reset paused", int'(d4_p), 0);
        check("reset step_out", int'(d4_so), 0);
        check("reset drop", int'(d4_drop), 0);
        check_model3("reset");
        rst = 1'b1;

        for (int i = 0; i < 30; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive_cycle(tbl[i].kp, tbl[i].key, tbl[i].stp, tbl[i].st);
            check({tag, " dir"}, int'(d4_dir), int'(tbl[i].dir));
            check({tag, " step_out"}, int'(d4_so), int'(tbl[i].so));
            check({tag, " paused"}, int'(d4_p), int'(tbl[i].p));
            check({tag, " count"}, int'(d4_cnt), int'(tbl[i].cnt));
            check({tag, " drop"}, int'(d4_drop), int'(tbl[i].drop));
            check_model3(tag);
        end

        // Start must also clear pause and the break flag.
        drive_cycle(1, 8'h29, 0, 0);
        drive_cycle(1, 8'hF0, 0, 0);
        drive_cycle(0, 8'h00, 0, 1);
        check("start clears pause", int'(d4_p), 0);
        drive_cycle(1, 8'h1D, 0, 0);
        check("start clears break", int'(d4_cnt), 1);
        check_model3("start");

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit         kp, stp, st;
            logic [7:0] k;
            int         r;
            r = $urandom_range(0, 9);
            case (r)
                0, 8:    k = 8'h1D;
                1, 9:    k = 8'h23;
                2:       k = 8'h1B;
                3:       k = 8'h1C;
                4:       k = 8'h29;
                5:       k = 8'hF0;
                6:       k = 8'hE0;
                default: k = 8'($urandom);
            endcase
            if (r == 2 || r == 3) k = ($urandom_range(0, 1) == 0) ? 8'h1B : 8'h1C;
            kp  = ($urandom_range(0, 1) == 1);
            stp = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 59) == 0);
            drive_cycle(kp, k, stp, st);
            check_model4("rand");
            check_model3("rand");
        end

        // Asynchronous reset in the middle of a cycle with a non-trivial state.
        drive_cycle(0, 8'h00, 0, 1);
        drive_cycle(1, 8'h1D, 0, 0);
        drive_cycle(0, 8'h00, 1, 0);
        drive_cycle(1, 8'h1C, 0, 0);
        drive_cycle(1, 8'h29, 0, 0);
        check("pre-reset dir", int'(d4_dir), 0);
        check("pre-reset count", int'(d4_cnt), 1);
        #2 rst = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_model4("async rst");
        check_model3("async rst");
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(0, 8'h00, 1, 0);
        check("post-reset step_out", int'(d4_so), 1);
        check("post-reset dir", int'(d4_dir), 1);
        check_model3("post rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
Parametrised successor to the game's keyboard direction control. It decodes PS/2 make codes into snake directions and buffers up to DEPTH pending turns in a FIFO, so fast key sequences within one game tick are not lost. It filters reversals and duplicate turns, adds a pause toggle, and gates the game step. It sits between the keyboard decoder, the tick timer and snake_calculate.

Parameters:
DEPTH, 4, pending-turn FIFO depth (>=1, any integer)
INIT_DIR, 2'd1, direction after reset/start (0 up, 1 right, 2 down, 3 left)
KEY_UP, 8'h1D, make code for up (W)
KEY_RIGHT, 8'h23, make code for right (D)
KEY_DOWN, 8'h1B, make code for down (S)
KEY_LEFT, 8'h1C, make code for left (A)
KEY_PAUSE, 8'h29, make code for pause toggle (space)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
key  input  8  PS/2 scan code byte from keyboard
key_pressed  input  1  one-cycle strobe, key valid
step  input  1  one-cycle game tick from tick_timer
start  input  1  restart strobe (death/new game)
snake_dir  output  2  committed direction for snake_calculate
step_out  output  1  gated tick, one cycle, snake_dir already valid
paused  output  1  pause state
queue_count  output  $clog2(DEPTH+1)  pending turns in FIFO
drop  output  1  one-cycle pulse: valid turn discarded because FIFO full

Behaviour:
- Reset (rst=0, async): snake_dir=INIT_DIR, step_out=0, paused=0, queue_count=0, drop=0, break flag=0, FIFO pointers=0.
- Direction encoding: 0 up, 1 right, 2 down, 3 left; reverse(d)=d^2.
- Byte decode on key_pressed:
  - 8'hF0: set break flag.
  - 8'hE0: ignored, no state change.
  - Any other byte while break flag=1: byte discarded, break flag cleared.
  - Otherwise the byte is a make code.
- Pause make code: toggle paused.
- Direction make code d while paused=1: ignored, no drop pulse.
- Direction make code d while paused=0: compare against last = FIFO tail entry if count>0, else snake_dir.
  - d==last or d==reverse(last): discard silently.
  - Else, count<DEPTH: push d.
  - Else (count==DEPTH): discard and pulse drop for 1 cycle.
- On a step edge with paused=0, in the same clock edge:
  - If count>0: snake_dir <= head entry, pop.
  - step_out <= 1 for exactly one cycle.
  - snake_dir is therefore updated no later than the cycle step_out is high; latency step->step_out = 1 cycle.
- On a step edge with paused=1: step swallowed; step_out stays 0; FIFO unchanged.
- Push and pop in the same cycle:
  - Push comparison uses the pre-pop tail; with count==1 that is the entry being popped.
  - Full FIFO with a simultaneous pop accepts the push (no drop); count unchanged.
  - Empty FIFO: push only; the new entry is not popped until a later step.
- start=1: FIFO cleared, snake_dir=INIT_DIR, paused=0, break flag=0, step_out=0, drop=0.
  - start has priority over step and key_pressed in the same cycle; both are lost.
- Pointers wrap modulo DEPTH (non-power-of-2 must work). queue_count never exceeds DEPTH or underflows.
- Reset asserted mid-operation returns all state to reset values immediately; no partial pop.

Test Plan:
- Reset, DEPTH=4 -> snake_dir=1, queue_count=0, paused=0; a step pulse gives step_out high 1 cycle later with snake_dir=1.
- Keys 8'h1D then 8'h1C (up, left) within one tick -> queue_count=2; step1 -> snake_dir=0; step2 -> snake_dir=3, queue_count=0.
- With snake_dir=1 (right), press 8'h1C (left, reverse) and 8'h23 (right, duplicate) -> queue_count stays 0, drop=0.
- Fill 4 alternating valid turns (up, right, up, right), press down -> drop pulses 1 cycle, count=4; repeat with step in the same cycle as the 5th key -> no drop, count stays 4.
- Press 8'h29, pulse step 3 times -> no step_out, paused=1, a direction key is ignored; press 8'h29 again -> next step produces step_out.
- Sequence F0,1D -> no push; then start with count=3 and step in the same cycle -> count=0, snake_dir=INIT_DIR, no step_out.
